// File: rtl/prenc_rr_arb_pkg.sv
// Shared types and helpers for the prenc_rr_arb registered priority arbiter.
// Imported by the interface, the encoder core and the arbiter top.
package prenc_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prenc_rr_arb_if.sv
// Request/grant bundle between request sources (master) and the arbiter (slave).
interface prenc_rr_arb_if #(parameter int N = 8);
  import prenc_pkg::*;

  localparam int IW = idx_width(N);

  logic [N-1:0]  req;
  logic          mode_rr;
  logic          gnt_ready;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_onehot;
  logic [IW-1:0] rr_ptr;

  modport master (
    output req, mode_rr, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot, rr_ptr
  );

  modport slave (
    input  req, mode_rr, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot, rr_ptr
  );

endinterface

// File: rtl/prenc_rr_arb_core.sv
// Combinational priority encoder: index of the highest set bit plus an any flag.
module prenc_core
  import prenc_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prenc_rr_arb.sv
// Registered fixed-priority / round-robin arbiter with a valid/ready grant.
// A held grant is stable until accepted; accepts re-arbitrate in the same cycle.
module prenc_rr_arb
  import prenc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  prenc_rr_arb_if.slave  bus
);

  localparam int IW = idx_width(N);

  arb_state_t    state_q, state_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]  gnt_onehot_q, gnt_onehot_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  logic            accept;
  int              rot;
  logic [2*N-1:0]  dbl_req;
  logic [N-1:0]    rot_req;
  logic [IW-1:0]   enc_idx;
  logic            enc_any;
  logic [IW-1:0]   win_idx;

  // Pointer moves first so re-arbitration after an accept sees the new priority.
  // Rotating left by N-1-ptr puts the pointer's line on the encoder's top bit.
  always_comb begin
    accept   = (state_q == GRANT) && bus.gnt_ready;
    rr_ptr_d = rr_ptr_q;
    if (accept && (bus.mode_rr == MODE_RR)) begin
      rr_ptr_d = (gnt_idx_q == '0) ? IW'(N - 1) : gnt_idx_q - IW'(1);
    end
    rot     = (bus.mode_rr == MODE_RR) ? (N - 1 - int'(rr_ptr_d)) : 0;
    dbl_req = {bus.req, bus.req} << rot;
    rot_req = dbl_req[2*N-1:N];
  end

  prenc_core #(.N(N)) u_core (
    .vec (rot_req),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_comb begin
    win_idx      = IW'((int'(enc_idx) + N - rot) % N);
    state_d      = state_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    if ((state_q == IDLE) || accept) begin
      if (enc_any) begin
        state_d      = GRANT;
        gnt_valid_d  = 1'b1;
        gnt_idx_d    = win_idx;
        gnt_onehot_d = N'(1) << win_idx;
      end else begin
        state_d      = IDLE;
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      rr_ptr_q     <= IW'(N - 1);
    end else begin
      state_q      <= state_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_prenc_rr_arb.sv
// Scoreboard bench for prenc_rr_arb: an N=4 instance for most scenarios, N=5 for wrap checks.
module tb_prenc_rr_arb;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic       rdy;
    logic       ev;
    logic [1:0] eidx;
    logic [1:0] eptr;
  } vec4_t;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       mode;
    logic       rdy;
    logic       ev;
    logic [2:0] eidx;
    logic [2:0] eptr;
  } vec5_t;

  logic clk;
  logic rst4;
  logic rst5;
  int   n_vec;
  int   n_err;

  vec4_t sb4[$];
  vec5_t sb5[$];

  prenc_rr_arb_if #(.N(4)) bus4 ();
  prenc_rr_arb_if #(.N(5)) bus5 ();

  prenc_rr_arb #(.N(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  prenc_rr_arb #(.N(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input vec4_t v);
    rst4           = v.rst;
    bus4.req       = v.req;
    bus4.mode_rr   = v.mode;
    bus4.gnt_ready = v.rdy;
  endtask

  task automatic drive5(input vec5_t v);
    rst5           = v.rst;
    bus5.req       = v.req;
    bus5.mode_rr   = v.mode;
    bus5.gnt_ready = v.rdy;
  endtask

  task automatic do_reset4();
    rst4 = 1'b1; bus4.req = 4'b0000; bus4.mode_rr = 1'b0; bus4.gnt_ready = 1'b0;
    tick();
    rst4 = 1'b0;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; bus4.req = 4'b1111; bus4.mode_rr = 1'b0; bus4.gnt_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (bus4.gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset[%0d] gnt_valid got %b want 0", k, bus4.gnt_valid); end
      n_vec++;
      if (bus4.gnt_onehot !== 4'b0000) begin n_err++; $display("[TB] FAIL reset[%0d] gnt_onehot got %b want 0000", k, bus4.gnt_onehot); end
      n_vec++;
      if (bus4.rr_ptr !== 2'd3) begin n_err++; $display("[TB] FAIL reset[%0d] rr_ptr got %0d want 3", k, bus4.rr_ptr); end
      n_vec++;
      if (bus4.gnt_idx !== 2'd0) begin n_err++; $display("[TB] FAIL reset[%0d] gnt_idx got %0d want 0", k, bus4.gnt_idx); end
    end
    rst4 = 1'b0;
    #1;
    n_vec++;
    if (bus4.gnt_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_release gnt_valid got %b want 0", bus4.gnt_valid); end
    tick();
    n_vec++;
    if (bus4.gnt_valid !== 1'b1) begin n_err++; $display("[TB] FAIL reset_first gnt_valid got %b want 1", bus4.gnt_valid); end
    n_vec++;
    if (bus4.gnt_idx !== 2'd3) begin n_err++; $display("[TB] FAIL reset_first gnt_idx got %0d want 3", bus4.gnt_idx); end
    n_vec++;
    if (bus4.gnt_onehot !== 4'b1000) begin n_err++; $display("[TB] FAIL reset_first gnt_onehot got %b want 1000", bus4.gnt_onehot); end
  endtask

  task automatic test_fixed();
    vec4_t tbl [6];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3},
            '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3},
            '{1'b0, 4'b0110, 1'b0, 1'b1, 1'b1, 2'd2, 2'd3},
            '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 2'd3},
            '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 2'd3},
            '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3}};
    for (int k = 0; k < 6; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL fixed[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL fixed[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL fixed[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL fixed[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_rr_fair();
    vec4_t tbl [9];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1},
            '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0}};
    for (int k = 0; k < 9; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL rr_fair[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL rr_fair[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL rr_fair[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL rr_fair[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_backpressure();
    vec4_t tbl [8];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2},
            '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2},
            '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0}};
    for (int k = 0; k < 8; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL backpressure[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL backpressure[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL backpressure[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL backpressure[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_mode_switch();
    vec4_t tbl [6];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b0011, 1'b0, 1'b0, 1'b1, 2'd1, 2'd3},
            '{1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 2'd1, 2'd3},
            '{1'b0, 4'b0011, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0},
            '{1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 2'd1, 2'd0},
            '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0},
            '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0}};
    for (int k = 0; k < 6; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL mode_switch[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL mode_switch[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL mode_switch[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL mode_switch[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_single();
    vec4_t tbl [5];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 2'd3},
            '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1},
            '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1},
            '{1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 2'd1},
            '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1}};
    for (int k = 0; k < 5; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL single[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL single[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL single[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL single[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_mid_reset();
    vec4_t tbl [5];
    vec4_t e;
    logic [3:0] exp_oh;
    do_reset4();
    tbl = '{'{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 2'd1},
            '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 2'd3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3}};
    for (int k = 0; k < 5; k++) begin
      drive4(tbl[k]); sb4.push_back(tbl[k]); tick();
      e = sb4.pop_front();
      exp_oh = e.ev ? (4'b0001 << e.eidx) : 4'b0000;
      n_vec++;
      if (bus4.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL mid_reset[%0d] gnt_valid got %b want %b", k, bus4.gnt_valid, e.ev); end
      n_vec++;
      if (bus4.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL mid_reset[%0d] rr_ptr got %0d want %0d", k, bus4.rr_ptr, e.eptr); end
      n_vec++;
      if (bus4.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL mid_reset[%0d] gnt_onehot got %b want %b", k, bus4.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus4.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL mid_reset[%0d] gnt_idx got %0d want %0d", k, bus4.gnt_idx, e.eidx); end
      end
    end
  endtask

  task automatic test_non_pow2();
    vec5_t tbl [8];
    vec5_t e;
    logic [4:0] exp_oh;
    tbl = '{'{1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd0, 3'd3},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd0, 3'd3},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd4, 3'd4},
            '{1'b0, 5'b10001, 1'b1, 1'b1, 1'b1, 3'd0, 3'd3},
            '{1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 3'd4}};
    for (int k = 0; k < 8; k++) begin
      drive5(tbl[k]); sb5.push_back(tbl[k]); tick();
      e = sb5.pop_front();
      exp_oh = e.ev ? (5'b00001 << e.eidx) : 5'b00000;
      n_vec++;
      if (bus5.gnt_valid !== e.ev) begin n_err++; $display("[TB] FAIL non_pow2[%0d] gnt_valid got %b want %b", k, bus5.gnt_valid, e.ev); end
      n_vec++;
      if (bus5.rr_ptr !== e.eptr) begin n_err++; $display("[TB] FAIL non_pow2[%0d] rr_ptr got %0d want %0d", k, bus5.rr_ptr, e.eptr); end
      n_vec++;
      if (bus5.gnt_onehot !== exp_oh) begin n_err++; $display("[TB] FAIL non_pow2[%0d] gnt_onehot got %b want %b", k, bus5.gnt_onehot, exp_oh); end
      if (e.ev) begin
        n_vec++;
        if (bus5.gnt_idx !== e.eidx) begin n_err++; $display("[TB] FAIL non_pow2[%0d] gnt_idx got %0d want %0d", k, bus5.gnt_idx, e.eidx); end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst4 = 1'b1; bus4.req = '0; bus4.mode_rr = 1'b0; bus4.gnt_ready = 1'b0;
    rst5 = 1'b1; bus5.req = '0; bus5.mode_rr = 1'b0; bus5.gnt_ready = 1'b0;
    test_reset();
    test_fixed();
    test_rr_fair();
    test_backpressure();
    test_mode_switch();
    test_single();
    test_mid_reset();
    test_non_pow2();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
